// File: rtl/param_ram_ctrl.sv
// param_ram_ctrl: single-port word RAM with byte-enable writes, a one-cycle
// request/response handshake, and a self-clearing sweep. The sweep runs after
// reset and after a clear request. It zeroes one word per cycle until the
// whole array has been written.
module param_ram_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter bit WR_RET_OLD = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                clr_req,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NBYTES = DATA_W / 8;

    // Two-state controller: sweeping the array to zero, or serving requests.
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Last word touched by the sweep.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // Depth held one bit wider so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_merged;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Handshake: requests are refused while sweeping and in a clear cycle.
    assign req_ready = (state_q == ST_READY) && !clr_req;
    assign accept    = req_valid && req_ready;
    assign init_done = (state_q == ST_READY);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Address decode and read of the word currently stored at req_addr.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        in_range = ({1'b0, req_addr} < DEPTH_X);
        rd_word  = '0;
        if (in_range) begin
            rd_word = mem_q[req_addr];
        end
    end

    // Byte-lane merge: enabled lanes take write data, the rest keep old data.
    always_comb begin
        wr_merged = rd_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (req_be[i]) begin
                wr_merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    // Controller next state: advance the sweep or restart it on a clear.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                if (clr_req) begin
                    sweep_d = '0;
                end else if (sweep_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d = ST_INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Single write port: the sweep owns it in INIT; accepted writes own it in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        if (state_q == ST_INIT) begin
            mem_we = 1'b1;
        end else if (accept && req_write && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = req_addr;
            mem_wdata = wr_merged;
        end
    end

    // Response for the request accepted this cycle; outputs stay zero when idle.
    always_comb begin
        rsp_valid_d = accept;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (accept) begin
            if (!in_range) begin
                rsp_err_d = 1'b1;
            end else if (!req_write) begin
                rsp_rdata_d = rd_word;
            end else if (WR_RET_OLD) begin
                rsp_rdata_d = rd_word;
            end
        end
    end

    // Control and response registers; reset abandons any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so all
            // flops see the pre-edge values and update together.
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset, so it can map to RAM. The sweep
        // defines its contents instead, and nothing reads them before it ends.
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Testbench for param_ram_ctrl. Three instances share one stimulus stream:
// the defaults, a write-returns-old-data variant, and a 20-word variant.
// A model array per instance predicts every response. The predictions go into
// a queue with the cycle in which they are due. A monitor running on the
// falling edge compares each cycle against the queue.
module tb_param_ram_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NB = DW / 8;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          clr_req = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;

    logic          req_ready [ND];
    logic          rsp_valid [ND];
    logic          rsp_err   [ND];
    logic          init_done [ND];
    logic [DW-1:0] rsp_rdata [ND];

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;

    exp_t          exp_q [ND][$];
    int            dep [ND]     = '{32, 32, 20};
    bit            ret_old [ND] = '{1'b0, 1'b1, 1'b0};
    logic [DW-1:0] mdl [ND][32];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .WR_RET_OLD(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clr_req(clr_req), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .init_done(init_done[0])
    );

    param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .WR_RET_OLD(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clr_req(clr_req), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .init_done(init_done[1])
    );

    param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20), .WR_RET_OLD(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clr_req(clr_req), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .init_done(init_done[2])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Response monitor: compare the due prediction, or expect idle zeros.
    exp_t mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
                mon_e = exp_q[k].pop_front();
                check($sformatf("rsp_valid[%0d] cyc=%0d", k, cyc), 32'(rsp_valid[k]), 32'd1);
                check($sformatf("rsp_rdata[%0d] cyc=%0d", k, cyc), 32'(rsp_rdata[k]), 32'(mon_e.data));
                check($sformatf("rsp_err[%0d] cyc=%0d", k, cyc), 32'(rsp_err[k]), 32'(mon_e.err));
            end else begin
                check($sformatf("idle_valid[%0d] cyc=%0d", k, cyc), 32'(rsp_valid[k]), 32'd0);
                check($sformatf("idle_rdata[%0d] cyc=%0d", k, cyc), 32'(rsp_rdata[k]), 32'd0);
                check($sformatf("idle_err[%0d] cyc=%0d", k, cyc), 32'(rsp_err[k]), 32'd0);
            end
        end
    end

    // Drive one request for one cycle and predict each instance's response.
    task automatic do_req(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NB-1:0] be);
        exp_t          e;
        logic [DW-1:0] old;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        for (int k = 0; k < ND; k++) begin
            if (int'(a) < dep[k]) begin
                old   = mdl[k][a];
                e.err = 1'b0;
                if (w) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[b]) mdl[k][a][8*b +: 8] = d[8*b +: 8];
                    end
                    e.data = ret_old[k] ? old : '0;
                end else begin
                    e.data = old;
                end
            end else begin
                e.err  = 1'b1;
                e.data = '0;
            end
            e.due = cyc + 1;
            exp_q[k].push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges from the start of a sweep and check the exact READY cycle.
    task automatic wait_init();
        for (int k = 0; k < ND; k++) begin
            check($sformatf("sweep_start_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
            check($sformatf("sweep_start_done[%0d]", k), 32'(init_done[k]), 32'd0);
        end
        for (int n = 1; n <= 34; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                check($sformatf("init_done[%0d] n=%0d", k, n), 32'(init_done[k]), 32'(n >= dep[k]));
                check($sformatf("req_ready[%0d] n=%0d", k, n), 32'(req_ready[k]), 32'(n >= dep[k]));
            end
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < ND; k++)
            for (int a = 0; a < 32; a++) mdl[k][a] = '0;
    endtask

    task automatic flush();
        for (int k = 0; k < ND; k++) exp_q[k].delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("%s_valid[%0d]", tag, k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("%s_rdata[%0d]", tag, k), 32'(rsp_rdata[k]), 32'd0);
            check($sformatf("%s_err[%0d]", tag, k), 32'(rsp_err[k]), 32'd0);
            check($sformatf("%s_ready[%0d]", tag, k), 32'(req_ready[k]), 32'd0);
            check($sformatf("%s_done[%0d]", tag, k), 32'(init_done[k]), 32'd0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) do_req(1'b0, AW'(a), '0, '0);
        idle(2);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Sweep after reset, then every word reads zero.
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        zero_model();
        read_all();

        // Byte-enable merges, no-op write, read-after-write.
        do_req(1'b1, 5'd7, 16'hA5C3, 2'b11);
        do_req(1'b0, 5'd7, '0, '0);
        do_req(1'b1, 5'd7, 16'hFFFF, 2'b01);
        do_req(1'b0, 5'd7, '0, '0);
        do_req(1'b1, 5'd7, 16'h0000, 2'b00);
        do_req(1'b0, 5'd7, '0, '0);
        do_req(1'b1, 5'd8, 16'h7E00, 2'b10);
        do_req(1'b0, 5'd8, '0, '0);
        idle(2);

        // Write returning the old word.
        do_req(1'b1, 5'd3, 16'hBEEF, 2'b11);
        do_req(1'b1, 5'd3, 16'h1234, 2'b11);
        do_req(1'b0, 5'd3, '0, '0);
        idle(1);

        // Range boundary on the 20-word instance.
        do_req(1'b1, 5'd25, 16'h5A5A, 2'b11);
        do_req(1'b0, 5'd25, '0, '0);
        do_req(1'b1, 5'd19, 16'hC0DE, 2'b11);
        do_req(1'b1, 5'd20, 16'hDEAD, 2'b11);
        do_req(1'b0, 5'd19, '0, '0);
        do_req(1'b0, 5'd20, '0, '0);
        do_req(1'b1, 5'd31, 16'h8001, 2'b11);
        idle(1);
        read_all();

        // Mixed traffic.
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                   DW'($urandom), NB'($urandom_range(0, 3)));
        end
        idle(1);
        read_all();

        // Clear in READY: the pending response issues, the held request is refused.
        do_req(1'b0, 5'd1, '0, '0);
        clr_req = 1'b1;
        #1;
        for (int k = 0; k < ND; k++)
            check($sformatf("clr_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
        @(posedge clk);
        #1;
        clr_req   = 1'b0;
        req_valid = 1'b0;
        wait_init();
        zero_model();
        read_all();

        // Clear during the sweep restarts it from address zero.
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        idle(9);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        wait_init();
        zero_model();
        do_req(1'b1, 5'd4, 16'h1357, 2'b11);
        do_req(1'b0, 5'd4, '0, '0);
        idle(1);

        // Reset with a response on the outputs abandons it at once.
        do_req(1'b0, 5'd4, '0, '0);
        req_valid = 1'b0;
        for (int k = 0; k < ND; k++)
            check($sformatf("pre_reset_valid[%0d]", k), 32'(rsp_valid[k]), 32'd1);
        rst_n = 1'b0;
        flush();
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset at sweep address 10, then a full sweep after release.
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("sweep_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        zero_model();
        read_all();

        idle(3);
        for (int k = 0; k < ND; k++)
            check($sformatf("queue_empty[%0d]", k), 32'(exp_q[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
